// File: rtl/idiv53_pkg.sv
// Shared types for idiv53: register bundle, reset value, counter markers and the
// radix-4 digit-select helper.
package idiv53_pkg;

  localparam logic [5:0] CNT_LAST = 6'd53;  // number of radix-4 iterations
  localparam logic [5:0] CNT_FIN  = 6'd63;  // marks "lshift done, raise rdy next"

  typedef struct packed {
    logic [105:0] dvd;       // dividend bits still to be shifted into the remainder
    logic [55:0]  rem;       // partial remainder
    logic [105:0] qout;      // quotient, two bits per iteration
    logic [55:0]  divx1;     // b
    logic [55:0]  divx3;     // 3*b
    logic [5:0]   cnt;
    logic         busy;
    logic         lz_stage;
    logic         rdy;
    logic [6:0]   lshift;
    logic         overflow;
  } idiv53_registers;

  localparam idiv53_registers idiv53_r_reset = '0;

  typedef struct packed {
    logic [1:0]  qd;
    logic [55:0] rem;
  } idiv53_digit;

  // Largest k in {0..3} with k*b <= r, plus the restored remainder r - k*b.
  function automatic idiv53_digit digit_select(input logic [55:0] r,
                                               input logic [55:0] bx1,
                                               input logic [55:0] bx3);
    idiv53_digit d;
    logic [55:0] bx2;
    bx2 = {bx1[54:0], 1'b0};
    if (r >= bx3) begin
      d.qd  = 2'd3;
      d.rem = r - bx3;
    end else if (r >= bx2) begin
      d.qd  = 2'd2;
      d.rem = r - bx2;
    end else if (r >= bx1) begin
      d.qd  = 2'd1;
      d.rem = r - bx1;
    end else begin
      d.qd  = 2'd0;
      d.rem = r;
    end
    return d;
  endfunction

endpackage

// File: rtl/idiv53_zeroenc.sv
// zeroenc: index of the lowest set bit of i_value; all ones when i_value is zero.
// Fed with a bit-reversed word it yields a leading-zero count.
module zeroenc #(
  parameter int iwidth     = 105,
  parameter int shiftwidth = 7
) (
  input  logic [iwidth-1:0]     i_value,
  output logic [shiftwidth-1:0] o_shift
);

  always_comb begin
    o_shift = '1;
    for (int i = iwidth - 1; i >= 0; i--) begin
      if (i_value[i]) o_shift = shiftwidth'(i);
    end
  end

endmodule

// File: rtl/idiv53.sv
// idiv53: iterative radix-4 restoring divider for double mantissas, Q = floor(a*2^104/b).
// Optional early termination on exact quotients is built when IDIV53_EARLY_EXIT_EN is defined.
module idiv53
  import idiv53_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_nrst,
  input  logic         i_ena,
  input  logic [52:0]  i_divident,
  input  logic [52:0]  i_divisor,
  output logic [104:0] o_result,
  output logic [6:0]   o_lshift,
  output logic         o_rdy,
  output logic         o_overflow
);

  // Handshake: i_ena is a one-cycle start pulse that samples the operands and
  // aborts any divide in flight; o_rdy is a one-cycle pulse when o_result,
  // o_lshift and o_overflow become valid; they then hold until the next i_ena.

  idiv53_registers r_regs;
  idiv53_registers w_nxt;
  logic [55:0]     w_rshift;
  idiv53_digit     w_dig;
  logic [5:0]      w_cnt_next;
  logic [104:0]    w_qrev;
  logic [6:0]      w_lz;
  logic            w_unused;
`ifdef IDIV53_EARLY_EXIT_EN
  logic [6:0]      w_shamt;
  logic [105:0]    w_qshift;
`endif

  always_comb begin
    for (int i = 0; i < 105; i++) w_qrev[i] = r_regs.qout[104-i];
  end

  zeroenc #(
    .iwidth    (105),
    .shiftwidth(7)
  ) u_zeroenc (
    .i_value(w_qrev),
    .o_shift(w_lz)
  );

  assign w_rshift   = {r_regs.rem[53:0], r_regs.dvd[105:104]};
  assign w_dig      = digit_select(w_rshift, r_regs.divx1, r_regs.divx3);
  assign w_cnt_next = r_regs.cnt + 6'd1;
  assign w_unused   = ^{r_regs.qout[105], r_regs.rem[55:54]};
`ifdef IDIV53_EARLY_EXIT_EN
  assign w_shamt    = {CNT_LAST - w_cnt_next, 1'b0};
  assign w_qshift   = {r_regs.qout[103:0], w_dig.qd} << w_shamt;
`endif

  always_comb begin : comb_proc
    w_nxt     = r_regs;
    w_nxt.rdy = 1'b0;
    if (i_ena) begin
      // a>>2 preloads the remainder so 53 digits cover exactly a*2^104.
      w_nxt.dvd      = {i_divident[1:0], 104'd0};
      w_nxt.rem      = {5'd0, i_divident[52:2]};
      w_nxt.qout     = '0;
      w_nxt.divx1    = {3'd0, i_divisor};
      w_nxt.divx3    = {3'd0, i_divisor} + {2'd0, i_divisor, 1'b0};
      w_nxt.cnt      = '0;
      w_nxt.busy     = 1'b1;
      w_nxt.lz_stage = 1'b0;
      w_nxt.overflow = 1'b0;
    end else if (r_regs.busy) begin
      if (r_regs.lz_stage) begin
        w_nxt.lz_stage = 1'b0;
        w_nxt.cnt      = CNT_FIN;
        if (r_regs.divx1 == '0) begin
          w_nxt.qout     = '1;
          w_nxt.lshift   = '0;
          w_nxt.overflow = 1'b1;
        end else begin
          w_nxt.lshift   = w_lz;
        end
      end else if (r_regs.cnt == CNT_FIN) begin
        w_nxt.rdy  = 1'b1;
        w_nxt.busy = 1'b0;
      end else begin
        w_nxt.dvd  = {r_regs.dvd[103:0], 2'b00};
        w_nxt.rem  = w_dig.rem;
        w_nxt.qout = {r_regs.qout[103:0], w_dig.qd};
        w_nxt.cnt  = w_cnt_next;
        if (w_cnt_next == CNT_LAST) w_nxt.lz_stage = 1'b1;
`ifdef IDIV53_EARLY_EXIT_EN
        if (w_dig.rem == '0 && r_regs.dvd[103:0] == '0 && r_regs.divx1 != '0) begin
          w_nxt.qout     = w_qshift;
          w_nxt.lz_stage = 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge i_clk) begin : rg_proc
    if (!i_nrst) r_regs <= idiv53_r_reset;
    else         r_regs <= w_nxt;
  end

  assign o_result   = r_regs.qout[104:0];
  assign o_lshift   = r_regs.lshift;
  assign o_rdy      = r_regs.rdy;
  assign o_overflow = r_regs.overflow;

endmodule

// File: tb/tb_idiv53.sv
// Testbench for idiv53: directed vector table, restart/reset sequences and a few
// random normalised operand pairs checked against a wide-integer golden model.
module tb_idiv53;

`ifdef IDIV53_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         nrst, ena, rdy, ovf;
  logic [52:0]  dvd, dvs;
  logic [104:0] res;
  logic [6:0]   lsh;

  int n_checks = 0;
  int n_pass   = 0;
  logic [104:0] exp_q[$];

  always #5 clk = ~clk;

  idiv53 dut (
    .i_clk     (clk),
    .i_nrst    (nrst),
    .i_ena     (ena),
    .i_divident(dvd),
    .i_divisor (dvs),
    .o_result  (res),
    .o_lshift  (lsh),
    .o_rdy     (rdy),
    .o_overflow(ovf)
  );

  typedef struct {
    logic [52:0]  a;
    logic [52:0]  b;
    logic [104:0] q;
    logic [6:0]   lz;
    logic         ov;
  } vec_t;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [104:0] golden_q(input logic [52:0] a, input logic [52:0] b);
    logic [159:0] num, q;
    if (b == '0) return '1;
    num = {a, 104'd0};
    q   = num / {107'd0, b};
    return q[104:0];
  endfunction

  function automatic logic [6:0] golden_lz(input logic [104:0] q);
    for (int i = 104; i >= 0; i--) if (q[i]) return 7'(104 - i);
    return 7'h7f;
  endfunction

  // Cycle of o_rdy counted from the edge that samples i_ena.
  function automatic int golden_lat(input logic [52:0] a, input logic [52:0] b);
    logic [159:0] d, pre, low_mask;
    int sh;
    if (!EARLY || b == '0) return 55;
    d = {a, 104'd0};
    for (int k = 1; k <= 52; k++) begin
      sh       = 2 * (53 - k);
      pre      = d >> sh;
      low_mask = (160'd1 << sh) - 160'd1;
      if ((d & low_mask) == '0 && (pre % {107'd0, b}) == '0) return k + 2;
    end
    return 55;
  endfunction

  task automatic start(input logic [52:0] a, input logic [52:0] b);
    @(negedge clk);
    dvd = a;
    dvs = b;
    ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
  endtask

  task automatic wait_rdy(output int lat);
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (rdy) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_one(input string nm, input logic [52:0] a, input logic [52:0] b,
                         input logic [104:0] eq, input logic [6:0] el, input logic eo);
    int lat;
    logic [104:0] e;
    exp_q.push_back(eq);
    start(a, b);
    check({nm, "_ovf_clr"}, 128'(ovf), 128'(1'b0));
    wait_rdy(lat);
    check({nm, "_lat"}, 128'(lat), 128'(golden_lat(a, b)));
    e = exp_q.pop_front();
    check({nm, "_result"}, 128'(res), 128'(e));
    check({nm, "_lshift"}, 128'(lsh), 128'(el));
    check({nm, "_ovf"}, 128'(ovf), 128'(eo));
    @(posedge clk);
    #1;
    check({nm, "_rdy_pulse"}, 128'(rdy), 128'(1'b0));
    check({nm, "_hold"}, 128'(res), 128'(e));
  endtask

  initial begin
    vec_t vecs[9];
    logic [104:0] ones;
    int lat, n_rdy;
    logic [52:0] ra, rb;
    logic [104:0] rq;

    ones    = '1;
    vecs[0] = '{53'd1 << 52, 53'd1 << 52, 105'd1 << 104, 7'd0, 1'b0};
    vecs[1] = '{53'd1 << 52, (53'd1 << 53) - 53'd1, (105'd1 << 103) + (105'd1 << 50), 7'd1, 1'b0};
    vecs[2] = '{53'd3 << 51, 53'd1 << 52, 105'd3 << 103, 7'd0, 1'b0};
    vecs[3] = '{(53'd1 << 53) - 53'd1, 53'd1 << 52, ones << 52, 7'd0, 1'b0};
    vecs[4] = '{53'd1 << 52, 53'd3 << 51, (ones - 105'd1) / 105'd3, 7'd1, 1'b0};
    vecs[5] = '{53'd1 << 52, (53'd1 << 52) + 53'd1, (105'd1 << 104) - (105'd1 << 52), 7'd1, 1'b0};
    vecs[6] = '{53'd0, 53'd1 << 52, 105'd0, 7'h7f, 1'b0};
    vecs[7] = '{53'd1 << 52, 53'd0, ones, 7'd0, 1'b1};
    vecs[8] = '{(53'd1 << 53) - 53'd1, (53'd1 << 53) - 53'd1, 105'd1 << 104, 7'd0, 1'b0};

    nrst = 1'b0;
    ena  = 1'b0;
    dvd  = '0;
    dvs  = '0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check("reset_result", 128'(res), 128'd0);
    check("reset_lshift", 128'(lsh), 128'd0);
    check("reset_rdy", 128'(rdy), 128'd0);
    check("reset_ovf", 128'(ovf), 128'd0);

    for (int i = 0; i < 9; i++)
      run_one($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].lz, vecs[i].ov);

    // Restart while busy: only the second operation completes.
    n_rdy = 0;
    start(53'd1 << 52, (53'd1 << 53) - 53'd1);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (rdy) n_rdy++;
    end
    start(53'd3 << 51, 53'd1 << 52);
    wait_rdy(lat);
    check("restart_early_rdy", 128'(n_rdy), 128'd0);
    check("restart_lat", 128'(lat), 128'(golden_lat(53'd3 << 51, 53'd1 << 52)));
    check("restart_result", 128'(res), 128'(105'd3 << 103));
    n_rdy = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (rdy) n_rdy++;
    end
    check("restart_single_rdy", 128'(n_rdy), 128'd0);

    // Reset mid-operation cancels it.
    start(53'd1 << 52, (53'd1 << 53) - 53'd1);
    repeat (29) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst  = 1'b1;
    n_rdy = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #1;
      if (rdy) n_rdy++;
    end
    check("midreset_no_rdy", 128'(n_rdy), 128'd0);
    check("midreset_result", 128'(res), 128'd0);
    check("midreset_lshift", 128'(lsh), 128'd0);
    check("midreset_ovf", 128'(ovf), 128'd0);

    for (int i = 0; i < 30; i++) begin
      ra = {1'b1, 20'($urandom), 32'($urandom)};
      rb = {1'b1, 20'($urandom), 32'($urandom)};
      rq = golden_q(ra, rb);
      run_one($sformatf("rnd%0d", i), ra, rb, rq, golden_lz(rq), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
